// File: rtl/sram_if.sv
// Wishbone-style request/response bundle between the cache-line wrapper and
// the SRAM bridge. The requester is the master; the bridge is the slave.
interface sram_if;
  logic        wb_stb;
  logic [31:0] wb_addr;
  logic [5:0]  wb_we;
  logic [47:0] wb_din;
  logic [47:0] wb_dout;
  logic        wb_nak;

  modport master (
    output wb_stb,
    output wb_addr,
    output wb_we,
    output wb_din,
    input  wb_dout,
    input  wb_nak
  );

  modport slave (
    input  wb_stb,
    input  wb_addr,
    input  wb_we,
    input  wb_din,
    output wb_dout,
    output wb_nak
  );
endinterface

// File: rtl/sram.sv
// Single-word bridge from the 48-bit bus to three side-by-side asynchronous
// 16-bit SRAM chips. Each access is SETUP -> STROBE -> HOLD (3 cycles); a new
// request may be accepted on the edge leaving HOLD so streaming runs at one
// word per 3 cycles. All pin controls are registered; only the data-bus
// output enable is decoded from registered state.
module sram (
  input  logic        clk,
  input  logic        rst,
  sram_if.slave       wb,
  output logic [2:0]  sram_ce_n,
  output logic [2:0]  sram_oe_n,
  output logic [2:0]  sram_we_n,
  output logic [2:0]  sram_ub_n,
  output logic [2:0]  sram_lb_n,
  output logic [19:0] sram_addr,
  inout  wire  [47:0] sram_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Low-byte enables of chips 2..0 live on the even mask bits.
  function automatic logic [2:0] f_lb_sel(input logic [5:0] we);
    return {we[4], we[2], we[0]};
  endfunction

  // High-byte enables of chips 2..0 live on the odd mask bits.
  function automatic logic [2:0] f_ub_sel(input logic [5:0] we);
    return {we[5], we[3], we[1]};
  endfunction

  state_t      r_state;
  logic [19:0] r_addr;
  logic [47:0] r_wdata;
  logic [47:0] r_dout;
  logic        r_write;
  logic        r_nak;
  logic [2:0]  r_ce_n;
  logic [2:0]  r_oe_n;
  logic [2:0]  r_we_n;
  logic [2:0]  r_ub_n;
  logic [2:0]  r_lb_n;

  logic        w_accept;
  logic        w_req_write;
  logic [2:0]  w_req_lb;
  logic [2:0]  w_req_ub;
  logic [2:0]  w_req_ce_n;
  logic [2:0]  w_req_oe_n;
  logic [2:0]  w_req_lb_n;
  logic [2:0]  w_req_ub_n;
  logic        w_drive;
  logic        w_unused_addr;

  // Only the word index selects SRAM rows; the rest of the byte address is don't-care.
  assign w_unused_addr = ^{wb.wb_addr[31:22], wb.wb_addr[1:0]};

  // A request is taken when idle, or when leaving HOLD so streaming needs no idle gap.
  assign w_accept = wb.wb_stb && ((r_state == S_IDLE) || (r_state == S_HOLD));

  // Decode the incoming request into the per-chip control pattern used for SETUP.
  always_comb begin
    w_req_write = |wb.wb_we;
    w_req_lb    = f_lb_sel(wb.wb_we);
    w_req_ub    = f_ub_sel(wb.wb_we);
    w_req_ce_n  = 3'b000;
    w_req_oe_n  = 3'b000;
    w_req_lb_n  = 3'b000;
    w_req_ub_n  = 3'b000;
    if (w_req_write) begin
      // Chips with no enabled byte stay deselected so their contents cannot change.
      w_req_ce_n = ~(w_req_lb | w_req_ub);
      w_req_oe_n = 3'b111;
      w_req_lb_n = ~w_req_lb;
      w_req_ub_n = ~w_req_ub;
    end
  end

  // Access sequencer: latches the request and steps the SRAM pin controls through one access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_write <= 1'b0;
      r_nak   <= 1'b0;
      r_ce_n  <= 3'b111;
      r_oe_n  <= 3'b111;
      r_we_n  <= 3'b111;
      r_ub_n  <= 3'b111;
      r_lb_n  <= 3'b111;
    end else if (w_accept) begin
      r_state <= S_SETUP;
      r_addr  <= wb.wb_addr[21:2];
      r_wdata <= wb.wb_din;
      r_write <= w_req_write;
      r_nak   <= 1'b1;
      r_ce_n  <= w_req_ce_n;
      r_oe_n  <= w_req_oe_n;
      r_we_n  <= 3'b111;
      r_ub_n  <= w_req_ub_n;
      r_lb_n  <= w_req_lb_n;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_nak <= 1'b0;
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          // Write pulse reaches exactly the selected chips.
          if (r_write) begin
            r_we_n <= r_ce_n;
          end
        end
        S_STROBE: begin
          r_state <= S_HOLD;
          r_we_n  <= 3'b111;
          // Read data has had the full SETUP+STROBE window to settle.
          if (!r_write) begin
            r_dout <= sram_data;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          r_nak   <= 1'b0;
          r_ce_n  <= 3'b111;
          r_oe_n  <= 3'b111;
          r_we_n  <= 3'b111;
          r_ub_n  <= 3'b111;
          r_lb_n  <= 3'b111;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data is held on the pins from SETUP through HOLD; reset or IDLE releases it.
  assign w_drive   = r_write && (r_state != S_IDLE);
  assign sram_data = w_drive ? r_wdata : 48'hzzzz_zzzz_zzzz;

  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_addr  = r_addr;
  assign wb.wb_dout = r_dout;
  assign wb.wb_nak  = r_nak;

endmodule

// File: tb/tb_sram.sv
// Bench for the SRAM bridge: a behavioural SRAM chip model on the pins, a
// word-level reference memory, stimulus that queues each request, and a
// monitor that pops and checks every access the DUT performs.
module tb_sram;

  typedef struct {
    logic [19:0] addr;
    logic [5:0]  we;
    logic [47:0] din;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sram_ce_n;
  logic [2:0]  sram_oe_n;
  logic [2:0]  sram_we_n;
  logic [2:0]  sram_ub_n;
  logic [2:0]  sram_lb_n;
  logic [19:0] sram_addr;
  wire  [47:0] sram_data;

  int   checks = 0;
  int   errors = 0;
  tx_t  sb[$];
  tx_t  cur;
  int   phase = 0;
  logic [47:0] exp_dout = '0;
  logic [47:0] ref_mem  [0:63];
  logic [47:0] chip_mem [0:63];
  logic        chip_drive;

  sram_if bus();

  sram dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (bus),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] init_word(input int i);
    if (i == 0) return 48'h0000_1234_5678;
    return {16'(i * 40503 + 7), 32'(i * 32'd2654435761)};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic released();
    return (sram_data === 48'hzzzz_zzzz_zzzz) || (sram_data === 48'h0);
  endfunction

  // Chip model: reads drive the bus, writes land byte-wise while CE and WE are low.
  assign chip_drive = (sram_ce_n == 3'b000) && (sram_oe_n == 3'b000) && (sram_we_n == 3'b111);
  assign sram_data  = chip_drive ? chip_mem[sram_addr[5:0]] : 48'hzzzz_zzzz_zzzz;

  initial begin
    for (int i = 0; i < 64; i++) chip_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!sram_ce_n[k] && !sram_we_n[k]) begin
          if (!sram_lb_n[k]) chip_mem[sram_addr[5:0]][16*k +: 8]     = sram_data[16*k +: 8];
          if (!sram_ub_n[k]) chip_mem[sram_addr[5:0]][16*k + 8 +: 8] = sram_data[16*k + 8 +: 8];
        end
      end
    end
  end

  // Expected pin pattern for one access, straight from the byte-enable rules.
  task automatic exp_ctrl(input tx_t t, output logic [2:0] ce, output logic [2:0] oe,
                          output logic [2:0] lb, output logic [2:0] ub);
    if (t.we == 6'h0) begin
      ce = 3'b000; oe = 3'b000; lb = 3'b000; ub = 3'b000;
    end else begin
      oe = 3'b111;
      for (int k = 0; k < 3; k++) begin
        lb[k] = ~t.we[2*k];
        ub[k] = ~t.we[2*k+1];
        ce[k] = ~(t.we[2*k] | t.we[2*k+1]);
      end
    end
  endtask

  task automatic check_phase(input int ph);
    logic [2:0] ce, oe, lb, ub;
    exp_ctrl(cur, ce, oe, lb, ub);
    chk($sformatf("ph%0d_addr", ph), 48'(sram_addr), 48'(cur.addr));
    chk($sformatf("ph%0d_ce_n", ph), 48'(sram_ce_n), 48'(ce));
    chk($sformatf("ph%0d_oe_n", ph), 48'(sram_oe_n), 48'(oe));
    chk($sformatf("ph%0d_lb_ub_n", ph), 48'({sram_lb_n, sram_ub_n}), 48'({lb, ub}));
    if (ph == 2 && cur.we != 6'h0) chk("strobe_we_n", 48'(sram_we_n), 48'(ce));
    else chk($sformatf("ph%0d_we_n", ph), 48'(sram_we_n), 48'(3'b111));
    if (cur.we != 6'h0) chk($sformatf("ph%0d_wdata", ph), sram_data, cur.din);
    if (ph == 3) begin
      if (cur.we == 6'h0) begin
        exp_dout = ref_mem[cur.addr[5:0]];
      end else begin
        for (int b = 0; b < 6; b++)
          if (cur.we[b]) ref_mem[cur.addr[5:0]][8*b +: 8] = cur.din[8*b +: 8];
      end
    end
    chk($sformatf("ph%0d_dout", ph), bus.wb_dout, exp_dout);
  endtask

  // Monitor: follows each access by watching wb_nak and checks it against the queued request.
  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase    = 0;
        exp_dout = '0;
        sb.delete();
      end else if (phase == 0) begin
        if (bus.wb_nak) begin
          if (sb.size() == 0) begin
            chk("unexpected_access", 48'(sb.size()), 48'd1);
            cur = '{addr: sram_addr, we: 6'h0, din: '0};
          end else begin
            cur = sb.pop_front();
          end
          check_phase(1);
          phase = 1;
        end else begin
          chk("idle_ctrl", 48'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 48'h7FFF);
          chk("idle_bus", 48'(released()), 48'd1);
          chk("idle_dout", bus.wb_dout, exp_dout);
        end
      end else if (!bus.wb_nak) begin
        chk("nak_early", 48'(bus.wb_nak), 48'd1);
        phase = 0;
      end else if (phase == 1) begin
        check_phase(2);
        phase = 2;
      end else begin
        check_phase(3);
        phase = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.wb_nak && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.wb_nak) chk("idle_timeout", 48'(bus.wb_nak), 48'd0);
  endtask

  task automatic drive_req(input logic [19:0] w, input logic [5:0] we, input logic [47:0] din);
    logic [31:0] a;
    a = $urandom;
    a[21:2] = w;
    bus.wb_addr = a;
    bus.wb_we   = we;
    bus.wb_din  = din;
    bus.wb_stb  = 1'b1;
    sb.push_back('{addr: w, we: we, din: din});
  endtask

  task automatic issue(input logic [19:0] w, input logic [5:0] we, input logic [47:0] din);
    wait_idle();
    drive_req(w, we, din);
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] w;
    logic [5:0]  we;
    logic [47:0] din;

    bus.wb_stb  = 1'b0;
    bus.wb_addr = '0;
    bus.wb_we   = '0;
    bus.wb_din  = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 48'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 48'h7FFF);
    chk("rst_nak", 48'(bus.wb_nak), 48'd0);
    chk("rst_dout", bus.wb_dout, 48'h0);
    chk("rst_addr", 48'(sram_addr), 48'h0);
    chk("rst_bus", 48'(released()), 48'd1);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

    // Full write, then read of the preloaded word 0 and of the written word.
    issue(20'h4, 6'h3F, 48'h1234_5678_9ABC);
    issue(20'h0, 6'h00, 48'h0);
    issue(20'h4, 6'h00, 48'h0);

    // Partial write to one byte of chip 0, then read back to see the rest intact.
    issue(20'h8, 6'b000001, 48'hFFFF_FFFF_FF5A);
    issue(20'h8, 6'h00, 48'h0);

    // Strobe raised during the busy cycles of a write must not start an access.
    issue(20'h9, 6'b110000, 48'hBEEF_0000_0000);
    bus.wb_addr = 32'h0000_0100;
    bus.wb_we   = 6'h3F;
    bus.wb_din  = '1;
    bus.wb_stb  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;
    issue(20'h9, 6'h00, 48'h0);

    // Streaming: strobe held high for 16 reads, next request accepted every 3rd edge.
    wait_idle();
    drive_req(20'd0, 6'h00, 48'h0);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #1 drive_req(20'(i), 6'h00, 48'h0);
      @(posedge clk);
      @(posedge clk);
    end
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;

    // Randomized mix of reads and masked writes over 64 words.
    for (int i = 0; i < 40; i++) begin
      w   = 20'($urandom_range(0, 63));
      we  = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'h00;
      din = {16'($urandom), 32'($urandom)};
      issue(w, we, din);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the write strobe aborts the access; the word must be unchanged.
    issue(20'd5, 6'h3F, 48'hA5A5_5A5A_F00F);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_we_n", 48'(sram_we_n), 48'(3'b111));
    chk("abort_ce_n", 48'(sram_ce_n), 48'(3'b111));
    chk("abort_bus", 48'(released()), 48'd1);
    chk("abort_nak", 48'(bus.wb_nak), 48'd0);
    chk("abort_dout", bus.wb_dout, 48'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(20'd5, 6'h00, 48'h0);
    issue(20'd4, 6'h00, 48'h0);

    repeat (6) @(negedge clk);
    chk("sb_drained", 48'(sb.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram.md
# sram

Single-word bridge between the 48-bit Wishbone-style bus used by the SoC memory path and three external asynchronous 16-bit SRAM chips wired side by side as one 48-bit-wide array. Each accepted request performs one read or one byte-masked write of a 48-bit word. The block sits below the cache-line wrapper, which streams 16 word requests per line through it using `wb_nak` as the busy/flow-control signal.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `wb_stb`  in  1  request strobe, sampled on the rising edge.
- `wb_addr`  in  32  byte address; word index is `wb_addr[21:2]`, other bits ignored.
- `wb_we`  in  6  byte write enables. Bit 2k is the low byte of chip k and bit 2k+1 is its high byte. 0 = read; any nonzero value = write.
- `wb_din`  in  48  write data; chip k takes bits [16k+15:16k].
- `wb_dout`  out  48  registered read data; holds the last completed read.
- `wb_nak`  out  1  busy; high while an access is in flight.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  3 each  active-low per-chip controls; bit k is chip k.
- `sram_addr`  out  20  word address shared by all chips.
- `sram_data`  inout  48  SRAM data bus; chip k uses bits [16k+15:16k].

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- **IDLE**
  - On a rising edge with `wb_stb`=1, latch the request into registers and go to SETUP: `sram_addr`←`wb_addr[21:2]`, plus data, mask, and read/write flag.
  - With `wb_stb`=0, stay in IDLE.
- **SETUP** (1 cycle)
  - Drive `sram_addr`.
  - Read: all `ce_n`=0, `oe_n`=0, `ub_n`/`lb_n`=0, data bus released.
  - Write: `ce_n[k]`=~(we[2k]|we[2k+1]), `lb_n[k]`=~we[2k], `ub_n[k]`=~we[2k+1], `oe_n`=111, latched data driven onto `sram_data`, `we_n`=111.
- **STROBE** (1 cycle)
  - Write: `we_n[k]`=`ce_n[k]` (low only for enabled chips).
  - Read: controls unchanged; on the exiting edge, `wb_dout`←`sram_data`.
- **HOLD** (1 cycle)
  - `we_n`=111. Write data stays driven and `ce_n`/`oe_n` are unchanged, for hold time.
  - On the exiting edge go to IDLE: all controls→111, bus released.
- Disabled bytes are never modified in the SRAM.
- `wb_nak`=1 in SETUP, STROBE and HOLD; 0 in IDLE.
- `wb_stb` seen while busy is ignored and not queued. The requester re-presents the request once `wb_nak`=0.
- `sram_data` is driven only in SETUP/STROBE/HOLD of a write; otherwise it is high-Z.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - State IDLE.
  - `sram_ce_n`/`oe_n`/`we_n`/`ub_n`/`lb_n`=3'b111.
  - `sram_addr`=0, `sram_data` high-Z.
  - `wb_dout`=0, `wb_nak`=0.
- Reset mid-access aborts immediately: `we_n` rises asynchronously, the bus is released, and `wb_dout` is cleared.
- Request accepted at edge E0; `wb_nak` is high from E0 to E3, and the access occupies 3 cycles.
  - Read data is valid on `wb_dout` from E2 and is sampled from `sram_data` during the cycle between E1 and E2.
  - `wb_nak` is low after E3.
- Back-to-back: `wb_stb` held high is accepted again at E3, giving one access per 3 cycles.
- `wb_dout` changes only on read completion or reset; writes leave it unchanged.
- All outputs are registered except the `sram_data` tristate enable, which is derived from registered state.

## Test plan
- **Reset:** hold `rst`=0 → all control outputs 3'b111, `wb_nak`=0, `wb_dout`=0, `sram_data` high-Z. Release `rst` and keep `wb_stb`=0 for 5 cycles → outputs unchanged.
- **Full write:** `wb_addr`=32'h10, `wb_we`=6'h3F, `wb_din`=48'h123456789ABC.
  - `sram_addr`=20'h4, `sram_data`=48'h123456789ABC driven SETUP..HOLD.
  - `sram_we_n`=000 for exactly 1 cycle (STROBE); `wb_nak` high for 3 cycles; `wb_dout` unchanged.
- **Read:** `wb_addr`=0, `wb_we`=0; the bench drives `sram_data`=48'h000012345678 while `oe_n`=000.
  - `wb_dout`=48'h000012345678 two edges after acceptance; `wb_nak` falls after 3 cycles.
- **Partial write:** `wb_we`=6'b000001 → `ce_n`=110, `lb_n`=110, `ub_n`=111, `we_n`=110 pulsed one cycle; chips 1/2 untouched.
- **Streaming and busy:** `wb_stb` held high for 16 reads at addresses 0,4,…,60 → 16 accesses at 3-cycle spacing, `sram_addr` 0..15. Strobes raised during busy cycles start no extra access.
- **Reset mid-write:** assert `rst`=0 during STROBE → `we_n` returns to 111 immediately, bus high-Z, FSM in IDLE after release.
